// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU function codes,
// FSM state encoding and instruction field positions (bit 0 = MSB).
// Imported by alu_sequencer and regfile_4x4.
package alu_seq_pkg;

  typedef logic [0:3] nib_t;
  typedef logic [0:7] word_t;
  typedef logic [0:2] op_t;
  typedef logic [0:1] afs_t;

  localparam op_t OP_XOR  = 3'd0;
  localparam op_t OP_AND  = 3'd1;
  localparam op_t OP_OR   = 3'd2;
  localparam op_t OP_ADD  = 3'd3;
  localparam op_t OP_SUB  = 3'd4;
  localparam op_t OP_LDI  = 3'd5;
  localparam op_t OP_OUT  = 3'd6;
  localparam op_t OP_HALT = 3'd7;

  localparam afs_t AFS_XOR = 2'b00;
  localparam afs_t AFS_AND = 2'b01;
  localparam afs_t AFS_OR  = 2'b10;
  localparam afs_t AFS_ADD = 2'b11;

  // Field positions inside an ascending [0:7] instruction word.
  localparam int OP_HI  = 0;
  localparam int OP_LO  = 2;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 4;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 6;
  localparam int IMM_HI = 0;
  localparam int IMM_LO = 3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_OUTP   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ADD and SUB share the adder code; SUB is distinguished by alu_sub.
  function automatic afs_t op_to_afs(input op_t op);
    case (op)
      OP_XOR:  op_to_afs = AFS_XOR;
      OP_AND:  op_to_afs = AFS_AND;
      OP_OR:   op_to_afs = AFS_OR;
      default: op_to_afs = AFS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// Four 4-bit registers: two combinational read ports, one synchronous write
// port, synchronous active-high reset loading REG_INIT into every entry.
// Ports: clk, rst, we/waddr/wdata (write), raddr_a/rdata_a, raddr_b/rdata_b.
module regfile_4x4
  import alu_seq_pkg::*;
#(
  parameter nib_t REG_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  nib_t       wdata,
  input  logic [1:0] raddr_a,
  output nib_t       rdata_a,
  input  logic [1:0] raddr_b,
  output nib_t       rdata_b
);

  nib_t regs_q [4];
  nib_t regs_d [4];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-write value, so rd == rs uses the old contents.
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Control-side sequencer for an external 4-bit ALU: fetches 8-bit
// instructions (valid/ready), drives registered ALU operands/controls,
// writes the combinational ALU result back, and emits registers on a
// valid/ready output port.
// Ports: clk, rst (sync, active high), instr_valid/instr_ready/instr,
//        alu_sub/alu_afs/alu_a/alu_b/alu_res, out_valid/out_ready/out_data,
//        halted, and zflag when ALU_SEQ_ZFLAG_EN is defined.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter nib_t REG_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [0:7] instr,
  output logic       alu_sub,
  output logic [0:1] alu_afs,
  output logic [0:3] alu_a,
  output logic [0:3] alu_b,
  input  logic [0:3] alu_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:3] out_data,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic       zflag,
`endif
  output logic       halted
);

  state_t state_q, state_d;
  word_t  ir_q, ir_d;
  logic   alu_sub_q, alu_sub_d;
  afs_t   alu_afs_q, alu_afs_d;
  nib_t   alu_a_q, alu_a_d;
  nib_t   alu_b_q, alu_b_d;
  logic   out_valid_q, out_valid_d;
  nib_t   out_data_q, out_data_d;
`ifdef ALU_SEQ_ZFLAG_EN
  logic   zflag_q, zflag_d;
`endif

  op_t        ir_op;
  logic [1:0] ir_rd;
  logic [1:0] ir_rs;
  nib_t       rd_val;
  nib_t       rs_val;
  logic       rf_we;
  nib_t       rf_wdata;

  assign ir_op = ir_q[OP_HI:OP_LO];
  assign ir_rd = ir_q[RD_HI:RD_LO];
  assign ir_rs = ir_q[RS_HI:RS_LO];

  regfile_4x4 #(
    .REG_INIT (REG_INIT)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (ir_rd),
    .wdata   (rf_wdata),
    .raddr_a (ir_rd),
    .rdata_a (rd_val),
    .raddr_b (ir_rs),
    .rdata_b (rs_val)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    alu_sub_d   = alu_sub_q;
    alu_afs_d   = alu_afs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef ALU_SEQ_ZFLAG_EN
    zflag_d     = zflag_q;
`endif
    rf_we       = 1'b0;
    rf_wdata    = alu_res;

    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_LDI:  state_d = S_IMM;
          OP_OUT: begin
            out_data_d  = rd_val;
            out_valid_d = 1'b1;
            state_d     = S_OUTP;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            alu_a_d   = rd_val;
            alu_b_d   = rs_val;
            alu_afs_d = op_to_afs(ir_op);
            alu_sub_d = (ir_op == OP_SUB);
            state_d   = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        rf_we    = 1'b1;
        rf_wdata = alu_res;
`ifdef ALU_SEQ_ZFLAG_EN
        zflag_d  = (alu_res == 4'h0);
`endif
        state_d  = S_FETCH;
      end
      S_IMM: begin
        if (instr_valid) begin
          rf_we    = 1'b1;
          rf_wdata = instr[IMM_HI:IMM_LO];
          state_d  = S_FETCH;
        end
      end
      S_OUTP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      alu_sub_q   <= 1'b0;
      alu_afs_q   <= AFS_XOR;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      alu_sub_q   <= alu_sub_d;
      alu_afs_q   <= alu_afs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q     <= zflag_d;
`endif
    end
  end

  // Ready is masked during reset so no word is consumed by a state about
  // to be discarded.
  assign instr_ready = !rst && ((state_q == S_FETCH) || (state_q == S_IMM));
  assign halted      = (state_q == S_HALT);
  assign alu_sub     = alu_sub_q;
  assign alu_afs     = alu_afs_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
`ifdef ALU_SEQ_ZFLAG_EN
  assign zflag       = zflag_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, drives instruction words,
// and checks ALU controls, handshake timing and emitted register values.
module tb_alu_sequencer;

  localparam logic [3:0] REG_INIT_TB = 4'h3;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [0:7] instr;
  logic       alu_sub;
  logic [0:1] alu_afs;
  logic [0:3] alu_a;
  logic [0:3] alu_b;
  logic [0:3] alu_res;
  logic       out_valid;
  logic       out_ready;
  logic [0:3] out_data;
  logic       halted;
`ifdef ALU_SEQ_ZFLAG_EN
  logic       zflag;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] sb [$];

  always #5 clk = ~clk;

  // External ALU datapath model.
  always_comb begin
    case (alu_afs)
      2'b00:   alu_res = alu_a ^ alu_b;
      2'b01:   alu_res = alu_a & alu_b;
      2'b10:   alu_res = alu_a | alu_b;
      default: alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    endcase
  end

  alu_sequencer #(.REG_INIT(REG_INIT_TB)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_sub     (alu_sub),
    .alu_afs     (alu_afs),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef ALU_SEQ_ZFLAG_EN
    .zflag       (zflag),
`endif
    .halted      (halted)
  );

  // Present a word and hold it until the accepting edge; returns 1 ns after it.
  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: word %h never accepted (instr_ready=%b, required 1)", w, instr_ready);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid with out_ready high and consume the word.
  task automatic wait_out(output logic [3:0] d, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    d = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = 8'hA0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_forced: got %b required 0", instr_ready); end
    rst = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({halted, out_valid, out_data} !== 6'b0) begin
      n_bad++; $display("FAIL rst_outputs: halted=%b out_valid=%b out_data=%h required 0/0/0", halted, out_valid, out_data);
    end
    n_cmp++;
    if ({alu_sub, alu_afs, alu_a, alu_b} !== 11'b0) begin
      n_bad++; $display("FAIL rst_alu: sub=%b afs=%b a=%h b=%h required all 0", alu_sub, alu_afs, alu_a, alu_b);
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_fetch_ready: got %b required 1", instr_ready); end
`ifdef ALU_SEQ_ZFLAG_EN
    n_cmp++;
    if (zflag !== 1'b0) begin n_bad++; $display("FAIL rst_zflag: got %b required 0", zflag); end
`endif
  endtask

  task automatic test_add();
    logic [3:0] d; bit ok;
    send_word(8'hA0); send_word(8'h70);
    send_word(8'hA8); send_word(8'h90);
    send_word(8'h62);
    @(posedge clk); #1;
    n_cmp++;
    if ({alu_afs, alu_sub, alu_a, alu_b} !== {2'b11, 1'b0, 4'h7, 4'h9}) begin
      n_bad++; $display("FAIL add_alu: afs=%b sub=%b a=%h b=%h required 11/0/7/9", alu_afs, alu_sub, alu_a, alu_b);
    end
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready: got %b required 0", instr_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_t3: got %b required 1", instr_ready); end
    sb.push_back(4'h0);
    send_word(8'hC0);
    wait_out(d, ok);
    n_cmp++;
    if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL add_out: got %h valid=%b required 0", d, ok); end
  endtask

  task automatic test_sub();
    logic [3:0] d; bit ok;
    send_word(8'hA8); send_word(8'h30);
    send_word(8'hA0); send_word(8'h50);
    send_word(8'h88);
    @(posedge clk); #1;
    n_cmp++;
    if ({alu_afs, alu_sub, alu_a, alu_b} !== {2'b11, 1'b1, 4'h3, 4'h5}) begin
      n_bad++; $display("FAIL sub_alu: afs=%b sub=%b a=%h b=%h required 11/1/3/5", alu_afs, alu_sub, alu_a, alu_b);
    end
    sb.push_back(4'hE);
    send_word(8'hC8);
    wait_out(d, ok);
    n_cmp++;
    if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL sub_out: got %h valid=%b required e", d, ok); end
  endtask

  task automatic test_logic();
    logic [7:0] ops [3];
    logic [1:0] afs [3];
    logic [3:0] res [3];
    logic [3:0] d; bit ok;
    ops = '{8'h02, 8'h22, 8'h42};
    afs = '{2'b00, 2'b01, 2'b10};
    res = '{4'h6, 4'h8, 4'hE};
    for (int i = 0; i < 3; i++) begin
      send_word(8'hA0); send_word(8'hC0);
      send_word(8'hA8); send_word(8'hA0);
      send_word(ops[i]);
      @(posedge clk); #1;
      n_cmp++;
      if (alu_afs !== afs[i] || alu_sub !== 1'b0) begin
        n_bad++; $display("FAIL logic_afs[%0d]: afs=%b sub=%b required %b/0", i, alu_afs, alu_sub, afs[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL logic_ready[%0d]: got %b required 1", i, instr_ready); end
      // OUT accepted at t+3 must already see the written value.
      sb.push_back(res[i]);
      send_word(8'hC0);
      wait_out(d, ok);
      n_cmp++;
      if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL logic_out[%0d]: got %h valid=%b required %h", i, d, ok, res[i]); end
    end
  endtask

  task automatic test_out_stall();
    int n;
    logic [3:0] first;
    send_word(8'hB0); send_word(8'h50);
    sb.push_back(4'h5);
    out_ready = 1'b0;
    send_word(8'hD0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    first = out_data;
    instr_valid = 1'b1;
    instr = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== first || instr_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: valid=%b data=%h ready=%b required 1/%h/0", i, out_valid, out_data, instr_ready, first);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (first !== sb.pop_front()) begin n_bad++; $display("FAIL stall_data: got %h required 5", first); end
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_hs: got %b required 0", instr_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: ready=%b valid=%b required 1/0", instr_ready, out_valid);
    end
  endtask

  task automatic test_halt();
    logic [3:0] d; bit ok;
    send_word(8'hE0);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 8'hA0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1 || instr_ready !== 1'b0) begin
        n_bad++; $display("FAIL halt_hold[%0d]: halted=%b ready=%b required 1/0", i, halted, instr_ready);
      end
    end
    do_reset();
    #1;
    n_cmp++;
    if (halted !== 1'b0 || instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL halt_exit: halted=%b ready=%b required 0/1", halted, instr_ready);
    end
    sb.push_back(REG_INIT_TB);
    send_word(8'hC0);
    wait_out(d, ok);
    n_cmp++;
    if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL halt_r0_init: got %h valid=%b required %h", d, ok, REG_INIT_TB); end
    sb.push_back(REG_INIT_TB);
    send_word(8'hD8);
    wait_out(d, ok);
    n_cmp++;
    if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL halt_r3_init: got %h valid=%b required %h", d, ok, REG_INIT_TB); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] d; bit ok;
    send_word(8'hA0);
    @(posedge clk);
    do_reset();
    // 0x02 must decode as XOR r0,r1 (both REG_INIT), not load an immediate.
    send_word(8'h02);
    @(posedge clk); #1;
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_decoded: ready=%b required 0 (EXEC)", instr_ready); end
    sb.push_back(4'h0);
    send_word(8'hC0);
    wait_out(d, ok);
    n_cmp++;
    if (!ok || d !== sb.pop_front()) begin n_bad++; $display("FAIL midrst_xor: got %h valid=%b required 0", d, ok); end
  endtask

`ifdef ALU_SEQ_ZFLAG_EN
  task automatic test_zflag();
    send_word(8'h00);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (zflag !== 1'b1) begin n_bad++; $display("FAIL zflag_set: got %b required 1", zflag); end
    send_word(8'hA8); send_word(8'h30);
    n_cmp++;
    if (zflag !== 1'b1) begin n_bad++; $display("FAIL zflag_ldi_keep: got %b required 1", zflag); end
    send_word(8'h62);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (zflag !== 1'b0) begin n_bad++; $display("FAIL zflag_clear: got %b required 0", zflag); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_out_stall();
    test_halt();
    test_mid_reset();
`ifdef ALU_SEQ_ZFLAG_EN
    test_zflag();
`endif
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drained: %0d entries left, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side driver of the 4-bit ALU datapath.
- Accepts 8-bit instruction words over a valid/ready handshake and holds a 4x4-bit register file.
- Drives the ALU operand, function-select and subtract lines, then writes the ALU result back to the register file.
- Exposes register contents on a valid/ready output port.

Parameters:
- REG_INIT, 4'h0, reset value loaded into all four registers r0..r3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  sequencer accepts a word this cycle.
- instr  in  [0:7]  instruction word, bit 0 = MSB.
- alu_sub  out  1  ALU subtract control.
- alu_afs  out  [0:1]  ALU function select.
- alu_a  out  [0:3]  ALU operand A.
- alu_b  out  [0:3]  ALU operand B.
- alu_res  in  [0:3]  ALU result (combinational from alu_*).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  [0:3]  register value from OUT.
- halted  out  1  sequencer in HALT.

Behaviour:
- Instruction format: instr[0:2] = op, [3:4] = rd, [5:6] = rs, [7] ignored.
- Opcodes:
  - 0 XOR: rd = rd ^ rs
  - 1 AND: rd = rd & rs
  - 2 OR: rd = rd | rs
  - 3 ADD: rd = rd + rs
  - 4 SUB: rd = rd - rs
  - 5 LDI: two words; rd = second word [0:3], second word [4:7] ignored
  - 6 OUT: emit rd on the output port
  - 7 HALT
- ALU mapping:
  - afs 00 = XOR, 01 = AND, 10 = OR, 11 = ADD/SUB.
  - alu_sub = 1 only for SUB.
  - All arithmetic is modulo 16; carry/borrow is discarded.
- FSM states: FETCH, DECODE, EXEC, IMM, OUTP, HALT.
  - FETCH: instr_ready = 1. On instr_valid, capture instr into the IR, go to DECODE.
  - DECODE, ALU op: register alu_a = reg[rd], alu_b = reg[rs], alu_afs, alu_sub; go to EXEC.
  - DECODE, LDI: go to IMM.
  - DECODE, OUT: load out_data = reg[rd], set out_valid; go to OUTP.
  - DECODE, HALT: go to HALT.
  - EXEC: write alu_res into reg[rd]; go to FETCH.
  - IMM: instr_ready = 1. On instr_valid, reg[rd] = instr[0:3]; go to FETCH.
  - OUTP: out_valid and out_data held stable. On out_ready, clear out_valid; go to FETCH.
  - HALT: halted = 1, instr_ready = 0, instr_valid ignored. Only rst exits.
- Latency:
  - ALU op accepted at cycle t: DECODE at t+1, write at t+2, result readable from t+3.
  - The next instruction can be accepted at t+3.
  - rd == rs is legal and uses the pre-write value for both operands.
- alu_* outputs are registered and hold their last value outside DECODE/EXEC.
- instr_ready is combinational from state and forced to 0 while rst = 1.
- Reset, applied in any state including mid-IMM and mid-OUTP:
  - state = FETCH, r0..r3 = REG_INIT.
  - alu_sub = 0, alu_afs = 00, alu_a = alu_b = 0.
  - out_valid = 0, out_data = 0, halted = 0.
  - A pending LDI immediate is discarded; the next accepted word is decoded as an instruction.

Optional Feature:
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined: adds output zflag (1 bit, reset 0). zflag is updated in EXEC to (alu_res == 0). LDI, OUT and HALT leave it unchanged.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_XOR..OP_HALT
  - afs codes AFS_XOR, AFS_AND, AFS_OR, AFS_ADD
  - FSM state encoding
  - field-position constants for op/rd/rs
- Sub-module regfile_4x4: two combinational read ports, one synchronous write port, synchronous reset to REG_INIT.

Test Plan:
- LDI r0,7 (0xA0,0x70); LDI r1,9 (0xA8,0x90); ADD (0x62): alu_afs = 11, alu_sub = 0, alu_a = 7, alu_b = 9. Then OUT r0 (0xC0) -> out_data = 0x0 (wrap).
- r1 = 3, r0 = 5; SUB r1,r0 (0x88): alu_sub = 1, alu_afs = 11. OUT r1 (0xC8) -> out_data = 0xE.
- r0 = 0xC, r1 = 0xA (reloaded before each op):
  - XOR 0x02 -> r0 = 0x6
  - AND 0x22 -> r0 = 0x8
  - OR 0x42 -> r0 = 0xE
  - Each write lands exactly 2 cycles after the handshake.
- OUT with out_ready low for 5 cycles: out_valid held at 1, out_data stable, instr_ready = 0. instr_ready returns the cycle after the out_ready handshake.
- HALT (0xE0): halted = 1 and instr_ready = 0 for 10 cycles despite instr_valid = 1. Then rst: registers = REG_INIT, halted = 0, fetch resumes.
- Mid-operation reset:
  - rst in IMM after 0xA0: r0 unchanged; the next word 0x02 executes as XOR.
  - With ALU_SEQ_ZFLAG_EN: XOR r0,r0 (0x00) sets zflag = 1; a later nonzero result clears it.
